// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and the Booth pair codes {Q0, Q-1}.
package booth_mult_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  // {Q0, Q-1} patterns that require an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic logic [1:0] booth_pair(input logic q0, input logic q_m1);
    return {q0, q_m1};
  endfunction

endpackage

// File: rtl/booth_mult_seq_add_sub.sv
// Plain combinational adder/subtractor: y = sub ? a - b : a + b.
module add_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// Self-sequencing radix-2 Booth multiplier. One start pulse runs WIDTH+1
// iterations on (WIDTH+1)-bit extended operands; done pulses for one cycle
// when product updates. Supports signed/unsigned mode and synchronous abort.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // One extension bit lets unsigned operands run through signed Booth exactly
  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);

  state_t         state, state_next;
  logic [E-1:0]   m_reg, a_reg, q_reg;
  logic           q_m1;
  logic [CW-1:0]  count;

  logic [E-1:0]   sum_diff, a_alu, a_next, q_next;
  logic           q_m1_next;
  logic           last_iter, accept, finish;

  // Subtract exactly when Q0=1; the result is only consumed for pairs 01/10
  add_sub #(.WIDTH(E)) u_add_sub (
    .a   (a_reg),
    .b   (m_reg),
    .sub (q_reg[0]),
    .y   (sum_diff)
  );

  // Select A+M, A-M or A from the current Booth pair
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    a_alu = a_reg;
    case (booth_pair(q_reg[0], q_m1))
      BOOTH_ADD, BOOTH_SUB: a_alu = sum_diff;
      default:              a_alu = a_reg;
    endcase
  end

  // Arithmetic right shift of {A', Q, Q-1}; A' sign bit replicated
  assign a_next    = {a_alu[E-1], a_alu[E-1:1]};
  assign q_next    = {a_alu[0], q_reg[E-1:1]};
  assign q_m1_next = q_reg[0];

  assign last_iter = (state == ST_CALC) && (count == LAST_COUNT);
  assign accept    = (state == ST_IDLE) && start && !abort;
  assign finish    = last_iter && !abort;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort beats both a new start and the final iteration
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && !abort)      state_next = ST_CALC;
      ST_CALC: if (abort || last_iter)   state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == ST_CALC);
  end

  // Operand load on accept, one Booth iteration per CALC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (accept) begin
      m_reg <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
      q_reg <= {signed_mode & multiplier[WIDTH-1], multiplier};
      a_reg <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (state == ST_CALC) begin
      if (abort) begin
        count <= '0;
      end else begin
        a_reg <= a_next;
        q_reg <= q_next;
        q_m1  <= q_m1_next;
        count <= count + 1'b1;
      end
    end
  end

  // Completion: one-cycle done pulse and product capture on the last iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= finish;
      if (finish) product <= {a_next[WIDTH-2:0], q_next};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: table of directed 8-bit vectors,
// hand-written multi-cycle corner sequences, and a 16-bit streaming run
// with start held high against an arithmetic reference model.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic reset;

  // 8-bit instance
  logic        start8, abort8, sm8;
  logic [7:0]  mc8, mp8;
  logic        busy8, done8;
  logic [15:0] product8;

  // 16-bit instance
  logic        start16, abort16, sm16;
  logic [15:0] mc16, mp16;
  logic        busy16, done16;
  logic [31:0] product16;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .start        (start8),
    .abort        (abort8),
    .signed_mode  (sm8),
    .multiplicand (mc8),
    .multiplier   (mp8),
    .busy         (busy8),
    .done         (done8),
    .product      (product8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .abort        (abort16),
    .signed_mode  (sm16),
    .multiplicand (mc16),
    .multiplier   (mp16),
    .busy         (busy16),
    .done         (done16),
    .product      (product16)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one 8-bit multiply and wait (bounded) for done.
  // lat counts clock edges from the accepting edge to the edge raising done.
  task automatic run8(input logic sm, input logic [7:0] mc, input logic [7:0] mp,
                      output logic [15:0] prod, output int lat, output int busy_cnt);
    @(negedge clk);
    sm8 = sm; mc8 = mc; mp8 = mp; start8 = 1'b1;
    @(posedge clk); #1;
    start8   = 1'b0;
    lat      = 0;
    busy_cnt = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) busy_cnt++;
    end
    prod = product8;
  endtask

  function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    logic signed [33:0] ea, eb, p;
    ea = sm ? {{18{a[15]}}, a} : {18'b0, a};
    eb = sm ? {{18{b[15]}}, b} : {18'b0, b};
    p  = ea * eb;
    return p[31:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] prod;
    logic [31:0] exp32;
    int lat, busy_cnt, dones, w, last_done;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2] = '{1'b1, 8'hFB, 8'h03, 16'hFFF1};
    vecs[3] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[4] = '{1'b0, 8'hFB, 8'h03, 16'h02F1};
    vecs[5] = '{1'b1, 8'h01, 8'hFF, 16'hFFFF};
    vecs[6] = '{1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[8] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
    vecs[9] = '{1'b0, 8'h0C, 8'h0A, 16'h0078};

    reset = 1'b1;
    start8 = 1'b0; abort8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
    start16 = 1'b0; abort16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8",    {31'b0, busy8}, 32'd0);
    check("rst_done8",    {31'b0, done8}, 32'd0);
    check("rst_product8", {16'b0, product8}, 32'd0);
    check("rst_busy16",   {31'b0, busy16}, 32'd0);
    check("rst_product16", product16, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors: product, 9-cycle latency, 9 busy cycles
    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].sm, vecs[i].mc, vecs[i].mp, prod, lat, busy_cnt);
      check($sformatf("vec%0d_product", i), {16'b0, prod}, {16'b0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), lat, 32'd9);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, 32'd9);
    end

    // Start re-pulsed while busy: ignored, single done with the original product
    @(negedge clk);
    sm8 = 1'b0; mc8 = 8'd12; mp8 = 8'd10; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dones = 0; lat = 0; prod = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        start8 = 1'b1; mc8 = 8'd5; mp8 = 8'd5; sm8 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) begin
        dones++;
        lat  = c;
        prod = product8;
      end
    end
    check("restart_done_count", dones, 32'd1);
    check("restart_latency", lat, 32'd9);
    check("restart_product", {16'b0, prod}, 32'h0078);

    // Abort mid-CALC: busy drops next cycle, no done, product held
    @(negedge clk);
    sm8 = 1'b0; mc8 = 8'd3; mp8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", {31'b0, busy8}, 32'd1);
    abort8 = 1'b1;
    @(posedge clk); #1;
    abort8 = 1'b0;
    check("abort_busy_after", {31'b0, busy8}, 32'd0);
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    check("abort_product_held", {16'b0, product8}, 32'h0078);

    // Abort together with start in IDLE: abort wins
    @(negedge clk);
    sm8 = 1'b0; mc8 = 8'd2; mp8 = 8'd2; start8 = 1'b1; abort8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; abort8 = 1'b0;
    check("idle_abort_start_busy", {31'b0, busy8}, 32'd0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    check("idle_abort_start_no_done", dones, 32'd0);

    // Reset mid-CALC clears outputs without a clock edge; then a fresh multiply
    @(negedge clk);
    sm8 = 1'b0; mc8 = 8'd9; mp8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("prereset_product", {16'b0, product8}, 32'h0078);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_busy",    {31'b0, busy8}, 32'd0);
    check("midreset_done",    {31'b0, done8}, 32'd0);
    check("midreset_product", {16'b0, product8}, 32'd0);
    #2;
    reset = 1'b0;
    run8(1'b0, 8'd7, 8'd6, prod, lat, busy_cnt);
    check("postreset_product", {16'b0, prod}, 32'h002A);
    check("postreset_latency", lat, 32'd9);

    // 16-bit streaming with start held high. A start is taken on the edge that
    // closes the done cycle, so completions are WIDTH+2 = 18 edges apart.
    @(negedge clk);
    sm16 = 1'b1; mc16 = 16'h8000; mp16 = 16'h8000;
    exp32 = ref16(sm16, mc16, mp16);
    start16 = 1'b1;
    last_done = 0;
    for (int i = 0; i < 1000; i++) begin
      w = 0;
      do begin
        @(posedge clk); #1;
        w++;
      end while (!done16 && w < 40);
      if (!done16) begin
        check("stream_done_timeout", {31'b0, done16}, 32'd1);
        break;
      end
      check($sformatf("stream%0d_product", i), product16, exp32);
      if (i > 0) check($sformatf("stream%0d_interval", i), cyc - last_done, 32'd18);
      last_done = cyc;
      sm16  = 1'($urandom_range(0, 1));
      mc16  = 16'($urandom);
      mp16  = 16'($urandom);
      exp32 = ref16(sm16, mc16, mp16);
    end
    start16 = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
